// File: rtl/dds_sweep_if.sv
// Sweep-controller bus: sweep configuration/control in, tuning word and status out.
// master = configuration side, slave = dds_sweep_ctrl.
interface dds_sweep_if #(
  parameter int ACC_LENGTH  = 48,
  parameter int DWELL_WIDTH = 16
);
  logic                   start;
  logic                   abort;
  logic                   continuous;
  logic [ACC_LENGTH-1:0]  start_freq;
  logic [ACC_LENGTH-1:0]  stop_freq;
  logic [ACC_LENGTH-1:0]  step;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [ACC_LENGTH-1:0]  increment;
  logic                   load_increment;
  logic                   busy;
  logic                   done;

  modport master (
    output start, abort, continuous, start_freq, stop_freq, step, dwell,
    input  increment, load_increment, busy, done
  );

  modport slave (
    input  start, abort, continuous, start_freq, stop_freq, step, dwell,
    output increment, load_increment, busy, done
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps phase_acc's tuning word from start to stop with a per-word dwell.
// Define DDS_SWEEP_BIDIR_EN for triangular up/down sweeps; default is an up-only sawtooth.
module dds_sweep_ctrl #(
  parameter int ACC_LENGTH  = 48,
  parameter int DWELL_WIDTH = 16
) (
  input logic       sys_clk,
  input logic       rst_n,
  dds_sweep_if.slave sweep
);

  typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;

  state_t                 state, state_nxt;
  logic [ACC_LENGTH-1:0]  cur, cur_nxt;
  logic [ACC_LENGTH-1:0]  start_s, stop_s, step_s;
  logic [DWELL_WIDTH-1:0] dwell_s, cnt, cnt_nxt;
  logic                   cont_s, degen;
  logic                   latch_cfg, decide;
  logic [ACC_LENGTH:0]    up_sum;
  logic [ACC_LENGTH-1:0]  up_word;
`ifdef DDS_SWEEP_BIDIR_EN
  logic                   dir, dir_nxt;
  logic [ACC_LENGTH:0]    dn_diff;
  logic [ACC_LENGTH-1:0]  dn_word;
`endif

  // Extra bit catches carry-out so a wrapping step clamps to stop instead of folding back.
  assign up_sum  = {1'b0, cur} + {1'b0, step_s};
  assign up_word = (up_sum >= {1'b0, stop_s}) ? stop_s : up_sum[ACC_LENGTH-1:0];
`ifdef DDS_SWEEP_BIDIR_EN
  assign dn_diff = {1'b0, cur} - {1'b0, step_s};
  assign dn_word = (dn_diff[ACC_LENGTH] || (dn_diff[ACC_LENGTH-1:0] <= start_s)) ?
                   start_s : dn_diff[ACC_LENGTH-1:0];
`endif

  // cur only changes on entry to LOAD, so it doubles as the held increment output.
  assign sweep.increment      = cur;
  assign sweep.load_increment = (state == LOAD);
  assign sweep.busy           = (state == LOAD) || (state == DWELL);
  assign sweep.done           = (state == DONE);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur     <= '0;
      cnt     <= '0;
      start_s <= '0;
      stop_s  <= '0;
      step_s  <= '0;
      dwell_s <= '0;
      cont_s  <= 1'b0;
      degen   <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      dir     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      cnt   <= cnt_nxt;
`ifdef DDS_SWEEP_BIDIR_EN
      dir   <= dir_nxt;
`endif
      if (latch_cfg) begin
        start_s <= sweep.start_freq;
        stop_s  <= sweep.stop_freq;
        step_s  <= sweep.step;
        dwell_s <= sweep.dwell;
        cont_s  <= sweep.continuous;
        degen   <= (sweep.step == '0) || (sweep.start_freq >= sweep.stop_freq);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    cnt_nxt   = cnt;
    latch_cfg = 1'b0;
    decide    = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
    dir_nxt   = dir;
`endif

    case (state)
      IDLE: begin
        if (sweep.start) begin
          latch_cfg = 1'b1;
          cur_nxt   = sweep.start_freq;
          state_nxt = LOAD;
`ifdef DDS_SWEEP_BIDIR_EN
          dir_nxt   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (dwell_s != '0) begin
          cnt_nxt   = dwell_s - DWELL_WIDTH'(1);
          state_nxt = DWELL;
        end else begin
          decide = 1'b1;
        end
      end
      DWELL: begin
        if (cnt == '0) decide = 1'b1;
        else           cnt_nxt = cnt - DWELL_WIDTH'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Next-word decision: endpoint handling, turn-around and clamping.
    if (decide) begin
`ifdef DDS_SWEEP_BIDIR_EN
      if (degen) begin
        if (cont_s) begin
          cur_nxt   = start_s;
          state_nxt = LOAD;
        end else begin
          state_nxt = DONE;
        end
      end else if (!dir) begin
        if (cur == stop_s) begin
          dir_nxt = 1'b1;
          cur_nxt = dn_word;
        end else begin
          cur_nxt = up_word;
        end
        state_nxt = LOAD;
      end else begin
        if (cur == start_s) begin
          if (cont_s) begin
            dir_nxt   = 1'b0;
            cur_nxt   = up_word;
            state_nxt = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          cur_nxt   = dn_word;
          state_nxt = LOAD;
        end
      end
`else
      if (degen || (cur == stop_s)) begin
        if (cont_s) begin
          cur_nxt   = start_s;
          state_nxt = LOAD;
        end else begin
          state_nxt = DONE;
        end
      end else begin
        cur_nxt   = up_word;
        state_nxt = LOAD;
      end
`endif
    end

    if (sweep.abort) begin
      state_nxt = IDLE;
      cur_nxt   = cur;
      cnt_nxt   = cnt;
      latch_cfg = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      dir_nxt   = dir;
`endif
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: directed sweeps push expected loads/done into a queue,
// a negedge monitor pops and compares word and cycle whenever the DUT strobes.
module tb_dds_sweep_ctrl;
  localparam int ACC = 48;
  localparam int DW  = 16;

  typedef struct {
    bit             is_done;
    logic [ACC-1:0] word;
    int             cycle;
  } exp_t;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  int             cyc   = 0;
  int             compared   = 0;
  int             mismatched = 0;
  exp_t           exp_q[$];
  logic [ACC-1:0] seq_q[$];

  dds_sweep_if #(.ACC_LENGTH(ACC), .DWELL_WIDTH(DW)) bus();

  dds_sweep_ctrl #(.ACC_LENGTH(ACC), .DWELL_WIDTH(DW)) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .sweep   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic atCycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expectSeq(input int n, input int dwell, input bit with_done);
    int len;
    len = seq_q.size();
    for (int i = 0; i < len; i++)
      exp_q.push_back('{is_done: 1'b0, word: seq_q[i], cycle: n + 1 + i * (dwell + 1)});
    if (with_done)
      exp_q.push_back('{is_done: 1'b1, word: '0, cycle: n + 1 + len * (dwell + 1)});
    seq_q.delete();
  endtask

  task automatic applyStimulus(input logic [ACC-1:0] s, input logic [ACC-1:0] p,
                               input logic [ACC-1:0] st, input logic [DW-1:0] d,
                               input bit cont, input bit ab, output int n);
    @(posedge clk);
    #1;
    bus.start_freq = s;
    bus.stop_freq  = p;
    bus.step       = st;
    bus.dwell      = d;
    bus.continuous = cont;
    bus.abort      = ab;
    bus.start      = 1'b1;
    n = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic runSweep(input string name, input logic [ACC-1:0] s, input logic [ACC-1:0] p,
                          input logic [ACC-1:0] st, input logic [DW-1:0] d);
    int n, len, done_cyc;
    len = seq_q.size();
    applyStimulus(s, p, st, d, 1'b0, 1'b0, n);
    expectSeq(n, int'(d), 1'b1);
    done_cyc = n + 1 + len * (int'(d) + 1);
    atCycle(n + 1);
    checkOutput({name, "_busy_first"}, 64'(bus.busy), 64'd1);
    atCycle(done_cyc - 1);
    checkOutput({name, "_busy_last"}, 64'(bus.busy), 64'd1);
    atCycle(done_cyc);
    checkOutput({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    atCycle(done_cyc + 2);
    checkOutput({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard in kind, word and cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (bus.load_increment === 1'b1) begin
        checkOutput("load_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("load_kind", 64'(e.is_done), 64'd0);
          checkOutput("load_word", 64'(bus.increment), 64'(e.word));
          checkOutput("load_cycle", 64'(cyc), 64'(e.cycle));
        end
      end
      if (bus.done === 1'b1) begin
        checkOutput("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("done_kind", 64'(e.is_done), 64'd1);
          checkOutput("done_cycle", 64'(cyc), 64'(e.cycle));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.continuous = 1'b0;
    bus.start_freq = '0;
    bus.stop_freq  = '0;
    bus.step       = '0;
    bus.dwell      = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_increment", 64'(bus.increment), 64'd0);
    checkOutput("reset_load", 64'(bus.load_increment), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;

    seq_q = '{48'd100, 48'd110, 48'd120, 48'd130};
`ifdef DDS_SWEEP_BIDIR_EN
    seq_q.push_back(48'd120); seq_q.push_back(48'd110); seq_q.push_back(48'd100);
`endif
    runSweep("basic", 48'd100, 48'd130, 48'd10, 16'd2);

    seq_q = '{48'd0, 48'd10, 48'd20, 48'd25};
`ifdef DDS_SWEEP_BIDIR_EN
    seq_q.push_back(48'd15); seq_q.push_back(48'd5); seq_q.push_back(48'd0);
`endif
    runSweep("clamp", 48'd0, 48'd25, 48'd10, 16'd0);

    seq_q = '{48'hFFFF_FFFF_FFF8, 48'hFFFF_FFFF_FFFF};
`ifdef DDS_SWEEP_BIDIR_EN
    seq_q.push_back(48'hFFFF_FFFF_FFF8);
`endif
    runSweep("overflow", 48'hFFFF_FFFF_FFF8, 48'hFFFF_FFFF_FFFF, 48'd16, 16'd0);

    seq_q = '{48'd500};
    runSweep("step_zero", 48'd500, 48'd900, 48'd0, 16'd1);

    seq_q = '{48'd700};
    runSweep("start_ge_stop", 48'd700, 48'd300, 48'd5, 16'd0);

    // Abort during the dwell of 110.
    seq_q = '{48'd100, 48'd110};
    applyStimulus(48'd100, 48'd130, 48'd10, 16'd5, 1'b0, 1'b0, n);
    expectSeq(n, 5, 1'b0);
    atCycle(n + 9);
    bus.abort = 1'b1;
    atCycle(n + 10);
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_increment", 64'(bus.increment), 64'd110);
    bus.abort = 1'b0;
    atCycle(n + 16);
    checkOutput("abort_held", 64'(bus.increment), 64'd110);
    checkOutput("abort_drained", 64'(exp_q.size()), 64'd0);

    applyStimulus(48'd200, 48'd300, 48'd10, 16'd0, 1'b0, 1'b1, n);
    checkOutput("start_abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("start_abort_load", 64'(bus.load_increment), 64'd0);
    atCycle(n + 4);
    checkOutput("start_abort_increment", 64'(bus.increment), 64'd110);
    checkOutput("start_abort_drained", 64'(exp_q.size()), 64'd0);

    // Continuous: no done ever; stopped by abort after six words.
`ifdef DDS_SWEEP_BIDIR_EN
    seq_q = '{48'd100, 48'd110, 48'd120, 48'd110, 48'd100, 48'd110};
`else
    seq_q = '{48'd100, 48'd110, 48'd120, 48'd100, 48'd110, 48'd120};
`endif
    applyStimulus(48'd100, 48'd120, 48'd10, 16'd0, 1'b1, 1'b0, n);
    expectSeq(n, 0, 1'b0);
    atCycle(n + 6);
    bus.abort = 1'b1;
    atCycle(n + 7);
    checkOutput("cont_abort_busy", 64'(bus.busy), 64'd0);
`ifdef DDS_SWEEP_BIDIR_EN
    checkOutput("cont_abort_increment", 64'(bus.increment), 64'd110);
`else
    checkOutput("cont_abort_increment", 64'(bus.increment), 64'd120);
`endif
    bus.abort = 1'b0;
    bus.continuous = 1'b0;
    atCycle(n + 10);
    checkOutput("cont_drained", 64'(exp_q.size()), 64'd0);

    // One-cycle reset in the middle of a sweep, then a normal sweep.
    seq_q = '{48'd100, 48'd110};
    applyStimulus(48'd100, 48'd130, 48'd10, 16'd2, 1'b0, 1'b0, n);
    expectSeq(n, 2, 1'b0);
    atCycle(n + 5);
    rst_n = 1'b0;
    atCycle(n + 6);
    checkOutput("midreset_increment", 64'(bus.increment), 64'd0);
    checkOutput("midreset_load", 64'(bus.load_increment), 64'd0);
    checkOutput("midreset_busy", 64'(bus.busy), 64'd0);
    checkOutput("midreset_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    checkOutput("midreset_drained", 64'(exp_q.size()), 64'd0);

    seq_q = '{48'd100, 48'd110, 48'd120, 48'd130};
`ifdef DDS_SWEEP_BIDIR_EN
    seq_q.push_back(48'd120); seq_q.push_back(48'd110); seq_q.push_back(48'd100);
`endif
    runSweep("after_reset", 48'd100, 48'd130, 48'd10, 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep scheduler for the DDS core. It drives the phase accumulator's `increment`/`load_increment` pair with a stepped sequence of tuning words, from a start word to a stop word, holding each word for a programmable dwell. It sits between the configuration registers and `phase_acc`, and replaces the SPI frequency register as the increment source while a sweep runs.

## Interface
- `ACC_LENGTH`, 48, width of the tuning word; matches the phase accumulator.
- `DWELL_WIDTH`, 16, width of the dwell counter.

- `sys_clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a sweep when idle.
- `abort`  in  1  level; terminates any sweep.
- `continuous`  in  1  repeat the sweep until aborted; sampled at start.
- `start_freq`  in  ACC_LENGTH  first tuning word; sampled at start.
- `stop_freq`  in  ACC_LENGTH  last tuning word; sampled at start.
- `step`  in  ACC_LENGTH  increment between words; sampled at start.
- `dwell`  in  DWELL_WIDTH  extra hold cycles per word; sampled at start.
- `increment`  out  ACC_LENGTH  tuning word to `phase_acc`.
- `load_increment`  out  1  one-cycle load strobe to `phase_acc`.
- `busy`  out  1  high from the first LOAD through the last dwell cycle.
- `done`  out  1  one-cycle pulse on normal sweep completion.

## Operation
- **States:**
  - IDLE: waits for `start`.
  - LOAD: drives `load_increment` high for exactly one cycle.
  - DWELL: counts `dwell` cycles down to 0.
  - DONE: one cycle; drives `done` high.
  - DONE then returns to IDLE.
- **Start:** in IDLE, `start` latches all config inputs into shadow registers, sets `cur = start_freq` and moves to LOAD. `start` is ignored in every other state.
- **LOAD:** drives `increment = cur` and `load_increment = 1`. Next state is DWELL if `dwell != 0`; otherwise the next-word decision is made immediately.
- **Next-word decision:** taken at the end of the final dwell cycle, or at the end of LOAD when `dwell = 0`.
  - If `cur == stop_freq`, the sweep ends: DONE, or a restart when continuous.
  - Otherwise `next = cur + step`, computed ACC_LENGTH+1 bits wide. If `next >= stop_freq` or it carries out, `cur = stop_freq`; else `cur = next`. Then go to LOAD.
- **Degenerate configuration:** `step == 0` or `start_freq >= stop_freq` loads `start_freq` once, dwells, then completes.
- **Continuous mode:** instead of entering DONE, sets `cur = start_freq` and goes to LOAD. `done` never pulses.
- **abort:** wins over everything, including a simultaneous `start`. Next cycle the state is IDLE, `busy = 0`, no `done`, and `increment` holds its last value.
- **`increment` holding:** `increment` is stable from its LOAD cycle until the next LOAD. It holds its value in IDLE.

## Timing
- **Reset values:** `increment = 0`, `load_increment = 0`, `busy = 0`, `done = 0`, state IDLE, shadow registers 0.
- **Start latency:** `start` sampled at cycle N gives the first `load_increment` at N+1.
- **Word period:** consecutive `load_increment` pulses are exactly `dwell + 1` cycles apart. With `dwell = 0`, a pulse occurs every cycle.
- **Completion:** `done` is high on the cycle after the last dwell cycle of `stop_freq`. `busy` is low on that same cycle.
- **`busy`:** high from N+1 until DONE or abort. The cycle after DONE accepts a new `start`.
- **Reset mid-sweep:** asserting `rst_n` low at any cycle returns all outputs to their reset values on the next edge. No `done` is produced.

## Configuration
- **Macro:** `DDS_SWEEP_BIDIR_EN`.
- **Defined:** sweeps are triangular.
  - After `stop_freq` is loaded, the direction reverses. `next = cur - step` with borrow; if it borrows or `next <= start_freq`, `cur = start_freq`.
  - Each endpoint is loaded once per turn-around.
  - Single-shot: completes after `start_freq` is reached on the down leg.
  - Continuous: reverses again at `start_freq`.
  - Degenerate configurations behave as above.
- **Undefined:** up-only sawtooth sweep as described in Operation; no down-count logic is present.

## Test plan
- **Basic sweep:** start=100, stop=130, step=10, dwell=2, `start` at N -> `load_increment` at N+1/4/7/10 with `increment` 100/110/120/130; `done` at N+13; `busy` high N+1..N+12.
- **Clamp:** start=0, stop=25, step=10, dwell=0 -> loads 0,10,20,25 on N+1..N+4; `done` at N+5.
- **Overflow and degenerate:** start=2^48-8, stop=2^48-1, step=16 -> loads 2^48-8 then 2^48-1 (clamp, no wrap). step=0 -> a single load of start_freq, then `done`.
- **Abort:** abort during the dwell of 110 (sweep 100->130, dwell=5) -> `busy` low next cycle, no `done`, `increment` stays 110. `start` together with `abort` -> stays IDLE.
- **Continuous:** start=100, stop=120, step=10, dwell=0, continuous -> 100,110,120,100,110,... with no `done`. With `DDS_SWEEP_BIDIR_EN`: 100,110,120,110,100,110,120.
- **Reset:** `rst_n` low mid-sweep for 1 cycle -> all outputs at reset values next cycle; a subsequent `start` is accepted and sweeps normally.
